// File: rtl/fp_compare_arbiter_pkg.sv
// Shared types for the FP comparator arbiter slice.
// OpTypes carries the comparator command; RvTypes carries word_t and fflags_t.
package OpTypes;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_LT  = 3'd1,
    CMP_LE  = 3'd2,
    CMP_MIN = 3'd3,
    CMP_MAX = 3'd4
  } FpComparatorCommand;

endpackage

package RvTypes;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

endpackage

// File: rtl/fp_compare_arbiter_if.sv
// Request/response bundle of fp_compare_arbiter.
// master = requesters and response consumer, slave = the arbiter.
interface fp_compare_arbiter_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4
);
  import OpTypes::*;
  import RvTypes::*;

  logic                 req0Valid;
  logic                 req0Ready;
  FpComparatorCommand   req0Command;
  logic [WIDTH-1:0]     req0Src1;
  logic [WIDTH-1:0]     req0Src2;
  logic [TAG_WIDTH-1:0] req0Tag;

  logic                 req1Valid;
  logic                 req1Ready;
  FpComparatorCommand   req1Command;
  logic [WIDTH-1:0]     req1Src1;
  logic [WIDTH-1:0]     req1Src2;
  logic [TAG_WIDTH-1:0] req1Tag;

  logic                 respValid;
  logic                 respReady;
  logic                 respRequester;
  logic [TAG_WIDTH-1:0] respTag;
  word_t                respIntResult;
  logic [WIDTH-1:0]     respFpResult;
  fflags_t              respFlags;

  fflags_t              stickyFlags;
  logic                 stickyClear;

  modport master (
    output req0Valid, req0Command, req0Src1, req0Src2, req0Tag,
    input  req0Ready,
    output req1Valid, req1Command, req1Src1, req1Src2, req1Tag,
    input  req1Ready,
    input  respValid, respRequester, respTag,
    input  respIntResult, respFpResult, respFlags,
    output respReady,
    input  stickyFlags,
    output stickyClear
  );

  modport slave (
    input  req0Valid, req0Command, req0Src1, req0Src2, req0Tag,
    output req0Ready,
    input  req1Valid, req1Command, req1Src1, req1Src2, req1Tag,
    output req1Ready,
    output respValid, respRequester, respTag,
    output respIntResult, respFpResult, respFlags,
    input  respReady,
    output stickyFlags,
    input  stickyClear
  );

endinterface

// File: rtl/fp_compare_arbiter_cmp.sv
// Combinational FP compare / min / max with RISC-V NaN and signed-zero rules.
// clk/rst are ports only so the unit can later be pipelined in place.
module FpComparator
  import OpTypes::*;
  import RvTypes::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23,
  parameter int WIDTH = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  FpComparatorCommand command,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  output word_t              int_result,
  output logic [WIDTH-1:0]   fp_result,
  output fflags_t            flags
);

  localparam logic [WIDTH-1:0] CANON_NAN =
    {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  function automatic logic fp_lt(input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y);
    if (~|{x[WIDTH-2:0], y[WIDTH-2:0]}) return 1'b0;
    if (x[WIDTH-1] != y[WIDTH-1]) return x[WIDTH-1];
    if (!x[WIDTH-1]) return x[WIDTH-2:0] < y[WIDTH-2:0];
    return y[WIDTH-2:0] < x[WIDTH-2:0];
  endfunction

  logic a_nan, b_nan, a_snan, b_snan, any_nan;
  logic both_zero, eq, lt_ab, lt_ba, min_a, max_a;

  assign a_nan  = (&src1[WIDTH-2:FRACTION_WIDTH]) && (|src1[FRACTION_WIDTH-1:0]);
  assign b_nan  = (&src2[WIDTH-2:FRACTION_WIDTH]) && (|src2[FRACTION_WIDTH-1:0]);
  assign a_snan = a_nan && !src1[FRACTION_WIDTH-1];
  assign b_snan = b_nan && !src2[FRACTION_WIDTH-1];
  assign any_nan = a_nan || b_nan;

  assign both_zero = ~|{src1[WIDTH-2:0], src2[WIDTH-2:0]};
  assign eq    = (src1 == src2) || both_zero;
  assign lt_ab = fp_lt(src1, src2);
  assign lt_ba = fp_lt(src2, src1);
  // -0 orders below +0 for min/max only
  assign min_a = lt_ab || (eq && src1[WIDTH-1]);
  assign max_a = lt_ba || (eq && !src1[WIDTH-1]);

  always_comb begin
    int_result = '0;
    fp_result  = '0;
    flags      = '0;
    case (command)
      CMP_EQ: begin
        flags.nv      = a_snan || b_snan;
        int_result[0] = !any_nan && eq;
      end
      CMP_LT: begin
        flags.nv      = any_nan;
        int_result[0] = !any_nan && lt_ab;
      end
      CMP_LE: begin
        flags.nv      = any_nan;
        int_result[0] = !any_nan && (lt_ab || eq);
      end
      CMP_MIN, CMP_MAX: begin
        flags.nv = a_snan || b_snan;
        if (a_nan && b_nan)            fp_result = CANON_NAN;
        else if (a_nan)                fp_result = src2;
        else if (b_nan)                fp_result = src1;
        else if (command == CMP_MIN)   fp_result = min_a ? src1 : src2;
        else                           fp_result = max_a ? src1 : src2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_compare_arbiter.sv
// Round-robin share of one FpComparator between two requesters, 2-deep resp FIFO.
// FP_COMPARE_STICKY_FLAGS_EN builds the sticky fflags accumulator.
module fp_compare_arbiter
  import OpTypes::*;
  import RvTypes::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23,
  parameter int WIDTH = 1 + EXPONENT_WIDTH + FRACTION_WIDTH,
  parameter int TAG_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  fp_compare_arbiter_if.slave bus
);

  localparam int DEPTH = 2;

  typedef struct packed {
    logic                 requester;
    logic [TAG_WIDTH-1:0] tag;
    word_t                int_result;
    logic [WIDTH-1:0]     fp_result;
    fflags_t              flags;
  } entry_t;

  entry_t mem [DEPTH];
  entry_t push_entry, head;

  logic [1:0] count;
  logic wptr, rptr, last_grant;
  logic grant, space, push, pop, resp_valid;

  FpComparatorCommand sel_cmd;
  logic [WIDTH-1:0] sel_a, sel_b;
  word_t cmp_int;
  logic [WIDTH-1:0] cmp_fp;
  fflags_t cmp_flags;

  assign resp_valid = count != 2'd0;
  assign pop   = resp_valid && bus.respReady;
  assign space = (count != 2'(DEPTH)) || pop;

  // with both valid the port that did not win last time goes next
  assign grant = (bus.req0Valid && bus.req1Valid) ? ~last_grant
                                                   : bus.req1Valid;
  assign bus.req0Ready = space && !grant;
  assign bus.req1Ready = space && grant;
  assign push = space && (grant ? bus.req1Valid : bus.req0Valid);

  assign sel_cmd = grant ? bus.req1Command : bus.req0Command;
  assign sel_a   = grant ? bus.req1Src1 : bus.req0Src1;
  assign sel_b   = grant ? bus.req1Src2 : bus.req0Src2;

  FpComparator #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .FRACTION_WIDTH(FRACTION_WIDTH),
    .WIDTH(WIDTH)
  ) u_cmp (
    .clk(clk),
    .rst(rst),
    .command(sel_cmd),
    .src1(sel_a),
    .src2(sel_b),
    .int_result(cmp_int),
    .fp_result(cmp_fp),
    .flags(cmp_flags)
  );

  always_comb begin
    push_entry.requester  = grant;
    push_entry.tag        = grant ? bus.req1Tag : bus.req0Tag;
    push_entry.int_result = cmp_int;
    push_entry.fp_result  = cmp_fp;
    push_entry.flags      = cmp_flags;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= 2'd0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push) begin
        wptr       <= ~wptr;
        last_grant <= grant;
      end
      if (pop) rptr <= ~rptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_entry;
  end

  assign head = mem[rptr];
  assign bus.respValid     = resp_valid;
  assign bus.respRequester = head.requester;
  assign bus.respTag       = head.tag;
  assign bus.respIntResult = head.int_result;
  assign bus.respFpResult  = head.fp_result;
  assign bus.respFlags     = head.flags;

`ifdef FP_COMPARE_STICKY_FLAGS_EN
  fflags_t sticky;

  // clear applies before the popped flags are merged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 sticky <= '0;
    else if (bus.stickyClear) sticky <= pop ? head.flags : '0;
    else if (pop)             sticky <= sticky | head.flags;
  end

  assign bus.stickyFlags = sticky;
`else
  logic unused_sticky_clear;
  assign unused_sticky_clear = bus.stickyClear;
  assign bus.stickyFlags = '0;
`endif

endmodule

// File: doc/fp_compare_arbiter.md
# fp_compare_arbiter

Shares one combinational `FpComparator` between two requesters, the FP execute pipe (port 0) and the FP move/convert sequencer (port 1). Each requester has a valid/ready request port. Grants are round-robin. Results are registered into a 2-entry response FIFO with a valid/ready output. Optionally keeps a sticky fflags accumulator for the CSR file.

## Interface
Parameters:
- `EXPONENT_WIDTH`, 8, exponent bits
- `FRACTION_WIDTH`, 23, fraction bits
- `WIDTH`, 1+EXPONENT_WIDTH+FRACTION_WIDTH, operand width (derived)
- `TAG_WIDTH`, 4, requester-supplied tag

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `req0Valid` / `req1Valid` in 1: request valid
- `req0Ready` / `req1Ready` out 1: request accepted this cycle when valid && ready
- `req0Command` / `req1Command` in FpComparatorCommand: Eq/Lt/Le/Min/Max
- `req0Src1`, `req0Src2`, `req1Src1`, `req1Src2` in WIDTH: operands
- `req0Tag` / `req1Tag` in TAG_WIDTH: returned unchanged with the response
- `respValid` out 1; `respReady` in 1: response handshake
- `respRequester` out 1: 0 = port 0, 1 = port 1
- `respTag` out TAG_WIDTH
- `respIntResult` out word_t
- `respFpResult` out WIDTH
- `respFlags` out fflags_t
- `stickyFlags` out fflags_t: accumulated flags
- `stickyClear` in 1: clear accumulator

## Operation
- `space = (count != 2) || (respValid && respReady)`.
- Grant:
  - Only one requester valid: that requester wins.
  - Both valid: the requester != `lastGrant` wins.
  - `reqNReady = space && grant==N`. At most one ready is high per cycle. Ready may depend on the other port's valid.
- `lastGrant` updates only on an accepted request.
- The accepted request drives the comparator combinationally. {requester, tag, intResult, fpResult, flags} are pushed into the FIFO in the same cycle.
- Command outside Eq/Lt/Le/Min/Max: the request is accepted; intResult, fpResult and flags are forced to 0.
- FIFO:
  - 2 entries, in order; count 0..2; pointers wrap at 2.
  - Push and pop in the same cycle leave count unchanged.
  - Pop on `respValid && respReady`.
- Sticky flags (macro on):
  - On pop: `stickyFlags |= respFlags`.
  - `stickyClear` alone: `stickyFlags` goes to 0 next cycle.
  - `stickyClear` with a pop: `stickyFlags` becomes the popped flags only (clear first, then set).

## Timing
- Reset values: `respValid` = 0, count = 0, pointers = 0, `lastGrant` = 1 (port 0 wins first), `stickyFlags` = 0.
  - Ready outputs still follow the combinational rule after reset: `req0Ready` = 1 whenever `req0Valid` = 1.
- Latency: request accepted in cycle N, `respValid` high in N+1 when the FIFO was empty.
- Throughput: 1 request/cycle while `respReady` is held high.
- Full FIFO with `respReady` = 0: both ready outputs are 0; the requester must hold its inputs stable.
- Response fields stay stable while `respValid && !respReady`.
- Reset asserted mid-operation: all FIFO contents are dropped, and `respValid` deasserts asynchronously.

## Configuration
- `FP_COMPARE_STICKY_FLAGS_EN` defined: accumulator is built as described above.
- Not defined: `stickyFlags` is tied to 0, `stickyClear` is ignored, and no accumulator flops are built.
- `respFlags` is unaffected by the macro.

## Structure
- Shared package OpTypes: `FpComparatorCommand`.
- Shared package RvTypes: `fflags_t`.
- Module-local: the FIFO entry struct; a localparam for FIFO depth = 2.
- Sub-module: one `FpComparator` instance. Its `clk`/`rst` are tied through.

## Test plan
- req0 Lt, Src1=0x3F800000, Src2=0x40000000, tag 3 -> next cycle: respValid=1, requester 0, tag 3, intResult 1, flags 0.
- Both ports valid continuously, respReady=1 -> grants alternate 0,1,0,1 starting with port 0; one response per cycle.
- respReady=0, req0 issues 3 requests (tags 1,2,3) -> tags 1,2 accepted, then req0Ready=0. After respReady=1: responses 1,2,3 in order, no loss.
- req1 Eq, Src1=0x7F800001 (sNaN), Src2=0x3F800000 -> intResult 0, flags.NV=1. With macro: stickyFlags.NV=1 until stickyClear, then 0 next cycle.
- Max, Src1=0x7FC00000, Src2=0x3F800000 -> fpResult 0x3F800000, flags 0. Invalid command -> all-zero response.
- FIFO holds 2 entries, rst driven low mid-cycle -> respValid=0 immediately, stickyFlags=0. After release, port 0 wins the first grant.
